gesture_debounce: RTL and testbench



---
 rtl/gesture_debounce_if.sv | 21 ++
 rtl/gesture_debounce.sv | 123 ++++++++++++
 tb/tb_gesture_debounce.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_debounce_if.sv
// Detector-to-qualifier bundle: per-frame direction sample in, qualified command and debug status out.
// The signal names are the block's port names, so the bundle reads the same as the flat port list.
interface gesture_debounce_if;
    logic       valid_in;
    logic [1:0] key_in;
    logic       present_in;
    logic [1:0] cmd_out;
    logic       cmd_valid_out;
    logic       held_out;
    logic [1:0] state_out;

    modport master (
        output valid_in, key_in, present_in,
        input  cmd_out, cmd_valid_out, held_out, state_out
    );

    modport slave (
        input  valid_in, key_in, present_in,
        output cmd_out, cmd_valid_out, held_out, state_out
    );
endinterface

// File: rtl/gesture_debounce.sv
// Frame-rate gesture qualifier: a direction code must hold for STABLE_FRAMES strobes to fire,
// then auto-repeats every REPEAT_FRAMES strobes; a missing-strobe watchdog drops back to IDLE.
module gesture_debounce #(
    parameter int STABLE_FRAMES  = 3,
    parameter int REPEAT_FRAMES  = 20,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    gesture_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CAND = 2'b01,
        ST_HELD = 2'b10
    } state_e;

    localparam logic [3:0]  STABLE_C    = 4'(STABLE_FRAMES);
    localparam logic [5:0]  REPEAT_C    = 6'(REPEAT_FRAMES);
    localparam logic [23:0] WDOG_LAST_C = 24'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [5:0]  rcnt_q, rcnt_d;
    logic [23:0] wdog_q, wdog_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;

    // Next-state logic; a strobe always takes priority over watchdog expiry
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        scnt_d      = scnt_q;
        rcnt_d      = rcnt_q;
        wdog_d      = wdog_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        if (bus.valid_in) begin
            wdog_d = 24'd0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.present_in) begin
                        cand_d  = bus.key_in;
                        scnt_d  = 4'd1;
                        state_d = ST_CAND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CAND: begin
                    if (!bus.present_in) begin
                        state_d = ST_IDLE;
                    end else if (bus.key_in != cand_q) begin
                        cand_d = bus.key_in;
                        scnt_d = 4'd1;
                    end else if (scnt_q + 4'd1 == STABLE_C) begin
                        cmd_d       = cand_q;
                        cmd_valid_d = 1'b1;
                        rcnt_d      = 6'd0;
                        state_d     = ST_HELD;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
                ST_HELD: begin
                    if (!bus.present_in) begin
                        state_d = ST_IDLE;
                    end else if (bus.key_in != cand_q) begin
                        cand_d  = bus.key_in;
                        scnt_d  = 4'd1;
                        state_d = ST_CAND;
                    end else if ((REPEAT_C != 6'd0) && (rcnt_q + 6'd1 == REPEAT_C)) begin
                        cmd_d       = cand_q;
                        cmd_valid_d = 1'b1;
                        rcnt_d      = 6'd0;
                    end else if (rcnt_q == 6'd63) begin
                        // Saturate so a disabled repeat can never wrap into a stray match
                        rcnt_d = rcnt_q;
                    end else begin
                        rcnt_d = rcnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (wdog_q == WDOG_LAST_C) begin
            state_d = ST_IDLE;
            wdog_d  = 24'd0;
        end else begin
            wdog_d = wdog_q + 24'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cand_q      <= 2'b00;
            scnt_q      <= 4'd0;
            rcnt_q      <= 6'd0;
            wdog_q      <= 24'd0;
            cmd_q       <= 2'b00;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            scnt_q      <= scnt_d;
            rcnt_q      <= rcnt_d;
            wdog_q      <= wdog_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign bus.cmd_out       = cmd_q;
    assign bus.cmd_valid_out = cmd_valid_q;
    assign bus.held_out      = (state_q == ST_HELD);
    assign bus.state_out     = state_q;

endmodule

// File: tb/tb_gesture_debounce.sv
// Bench for gesture_debounce: directed scenarios plus randomized strobes against a run-length model.
module tb_gesture_debounce;
    localparam int S = 3;
    localparam int R = 4;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gesture_debounce_if bus();

    gesture_debounce #(
        .STABLE_FRAMES(S),
        .REPEAT_FRAMES(R),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: length of the current unbroken run of present, identical strobes
    int         m_run_len = 0;
    logic [1:0] m_run_key = 2'b00;
    logic [1:0] m_cmd     = 2'b00;
    logic       m_pulse   = 1'b0;
    int         m_gap     = 0;
    int         dut_pulses = 0;
    int         mdl_pulses = 0;

    task automatic model_step(input logic v, input logic [1:0] k, input logic p, input logic r);
        m_pulse = 1'b0;
        if (r) begin
            m_run_len = 0; m_run_key = 2'b00; m_cmd = 2'b00; m_gap = 0;
        end else if (v) begin
            m_gap = 0;
            if (!p) m_run_len = 0;
            else if (m_run_len > 0 && k == m_run_key) m_run_len++;
            else begin m_run_key = k; m_run_len = 1; end
            if (p && (m_run_len == S || (m_run_len > S && (m_run_len - S) % R == 0))) begin
                m_pulse = 1'b1;
                m_cmd   = m_run_key;
            end
        end else begin
            m_gap++;
            if (m_gap == T) begin m_run_len = 0; m_gap = 0; end
        end
    endtask

    function automatic logic [5:0] expect_out();
        logic [1:0] st;
        st = (m_run_len == 0) ? 2'b00 : (m_run_len < S) ? 2'b01 : 2'b10;
        return {m_pulse, m_cmd, (m_run_len >= S), st};
    endfunction

    function automatic logic [5:0] observe();
        return {bus.cmd_valid_out, bus.cmd_out, bus.held_out, bus.state_out};
    endfunction

    task automatic cycle(input logic v, input logic [1:0] k, input logic p, input logic r);
        bus.valid_in = v; bus.key_in = k; bus.present_in = p; rst = r;
        model_step(v, k, p, r);
        @(posedge clk); #1;
        bus.valid_in = 1'b0; rst = 1'b0;
        bus.key_in = 2'($urandom_range(0, 3)); bus.present_in = 1'($urandom_range(0, 1));
        dut_pulses += int'(bus.cmd_valid_out);
        mdl_pulses += int'(m_pulse);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic strobe(input logic [1:0] k, input logic p, input int gap);
        idle(gap - 1);
        cycle(1'b1, k, p, 1'b0);
    endtask

    task automatic test_reset;
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        n_tests++;
        if (observe() !== 6'b0_00_0_00) begin
            n_fail++; $display("FAIL reset_values: got %b expected %b", observe(), 6'b0_00_0_00);
        end
    endtask

    task automatic test_fire_repeat;
        int p0;
        strobe(2'b00, 1'b0, 20);
        p0 = dut_pulses;
        for (int i = 1; i <= 11; i++) begin
            strobe(2'b10, 1'b1, 20);
            n_tests++;
            if (observe() !== expect_out()) begin
                n_fail++; $display("FAIL repeat_strobe%0d: got %b expected %b", i, observe(), expect_out());
            end
            if (i == 3) begin
                n_tests++;
                if (observe() !== 6'b1_10_1_10) begin
                    n_fail++; $display("FAIL first_fire: got %b expected %b", observe(), 6'b1_10_1_10);
                end
            end
        end
        n_tests++;
        if (dut_pulses - p0 != 3) begin
            n_fail++; $display("FAIL repeat_count: got %0d expected 3", dut_pulses - p0);
        end
    endtask

    task automatic test_key_change;
        logic [1:0] keys [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        int p0;
        strobe(2'b00, 1'b0, 20);
        p0 = dut_pulses;
        for (int i = 0; i < 5; i++) strobe(keys[i], 1'b1, 20);
        n_tests++;
        if (observe() !== 6'b1_11_1_10 || dut_pulses - p0 != 1) begin
            n_fail++; $display("FAIL key_change: got %b/%0d pulses expected %b/1", observe(), dut_pulses - p0, 6'b1_11_1_10);
        end
    endtask

    task automatic test_release;
        strobe(2'b00, 1'b0, 20);
        for (int i = 0; i < 3; i++) strobe(2'b00, 1'b1, 20);
        strobe(2'b00, 1'b0, 20);
        n_tests++;
        if (observe() !== 6'b0_00_0_00) begin
            n_fail++; $display("FAIL release: got %b expected %b", observe(), 6'b0_00_0_00);
        end
    endtask

    task automatic test_timeout;
        int p0;
        strobe(2'b00, 1'b0, 20);
        for (int i = 0; i < 3; i++) strobe(2'b11, 1'b1, 20);
        p0 = dut_pulses;
        idle(T - 1);
        n_tests++;
        if (observe() !== 6'b0_11_1_10) begin
            n_fail++; $display("FAIL timeout_early: got %b expected %b", observe(), 6'b0_11_1_10);
        end
        idle(1);
        n_tests++;
        if (observe() !== 6'b0_11_0_00 || dut_pulses != p0) begin
            n_fail++; $display("FAIL timeout_idle: got %b expected %b", observe(), 6'b0_11_0_00);
        end
        for (int i = 0; i < 3; i++) strobe(2'b11, 1'b1, 20);
        n_tests++;
        if (observe() !== 6'b1_11_1_10) begin
            n_fail++; $display("FAIL timeout_refire: got %b expected %b", observe(), 6'b1_11_1_10);
        end
    endtask

    task automatic test_reset_midfire;
        strobe(2'b00, 1'b0, 20);
        strobe(2'b01, 1'b1, 20);
        strobe(2'b01, 1'b1, 20);
        cycle(1'b0, 2'b01, 1'b1, 1'b1);
        n_tests++;
        if (observe() !== 6'b0_00_0_00) begin
            n_fail++; $display("FAIL reset_mid: got %b expected %b", observe(), 6'b0_00_0_00);
        end
        strobe(2'b01, 1'b1, 19);
        n_tests++;
        if (observe() !== 6'b0_00_0_01) begin
            n_fail++; $display("FAIL reset_no_fire: got %b expected %b", observe(), 6'b0_00_0_01);
        end
        strobe(2'b01, 1'b1, 20);
        strobe(2'b01, 1'b1, 20);
        n_tests++;
        if (observe() !== 6'b1_01_1_10) begin
            n_fail++; $display("FAIL reset_refire: got %b expected %b", observe(), 6'b1_01_1_10);
        end
    endtask

    task automatic test_back_to_back;
        strobe(2'b00, 1'b0, 20);
        for (int i = 0; i < 3; i++) strobe(2'b10, 1'b1, 1);
        n_tests++;
        if (observe() !== 6'b1_10_1_10) begin
            n_fail++; $display("FAIL b2b_fire: got %b expected %b", observe(), 6'b1_10_1_10);
        end
        idle(1);
        n_tests++;
        if (observe() !== 6'b0_10_1_10) begin
            n_fail++; $display("FAIL b2b_single_pulse: got %b expected %b", observe(), 6'b0_10_1_10);
        end
    endtask

    task automatic test_random;
        int gap;
        int errs = 0;
        for (int s = 0; s < 300; s++) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(95, 110) : $urandom_range(1, 25);
            for (int c = 0; c < gap; c++) begin
                if (c == gap - 1)
                    cycle(1'b1, 2'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
                else
                    cycle(1'b0, 2'($urandom_range(0, 3)), 1'b1, ($urandom_range(0, 499) == 0));
                n_tests++;
                if (observe() !== expect_out()) begin
                    n_fail++; errs++;
                    if (errs <= 10) $display("FAIL random_s%0d_c%0d: got %b expected %b", s, c, observe(), expect_out());
                end
            end
        end
        n_tests++;
        if (dut_pulses != mdl_pulses) begin
            n_fail++; $display("FAIL random_pulse_total: got %0d expected %0d", dut_pulses, mdl_pulses);
        end
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.key_in = 2'b00; bus.present_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fire_repeat();
        test_key_change();
        test_release();
        test_timeout();
        test_reset_midfire();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
